i2s_clk_ctrl: RTL and testbench

- Master-side timing controller for the I2S receive path.
- Derives bck and lrck from the system clock and sequences a programmed number of stereo frames (or runs continuously).
- Emits a per-channel sample strobe, aligned to the point where the receiver's 24-bit data_out word is complete, so downstream logic can capture left/right samples.
- Sits between the system clock domain and i2s_rcvr (drives its bck/lrck) plus the sample capture logic.

---
 rtl/i2s_clk_ctrl.sv | 147 ++++++++++++++
 tb/tb_i2s_clk_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_clk_ctrl.sv
// I2S master timing: derives bck/lrck from clk, sequences stereo frames and
// strobes each channel word once the receiver has shifted in DATA_BITS bits.
module i2s_clk_ctrl #(
  parameter int DATA_BITS = 24,
  parameter int SLOT_BITS = 32,
  parameter int BCK_DIV   = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [15:0]                  num_frames,
  output logic                         bck,
  output logic                         lrck,
  output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
  output logic                         sample_strobe,
  output logic                         sample_ch,
  output logic [15:0]                  frame_cnt,
  output logic                         busy,
  output logic                         done
);
  localparam int IDX_W = $clog2(SLOT_BITS);
  localparam int DIV_W = $clog2(BCK_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(SLOT_BITS - 1);
  localparam logic [IDX_W-1:0] STROBE_IDX = IDX_W'(DATA_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(BCK_DIV / 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic [15:0]      nf_q, nf_d;
  logic             bck_q, bck_d;
  logic             lrck_q, lrck_d;
  logic             strobe_q, strobe_d;
  logic             ch_q, ch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fe;
  logic             frame_end;
  logic             finish;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    idx_d     = idx_q;
    fcnt_d    = fcnt_q;
    nf_d      = nf_q;
    bck_d     = bck_q;
    lrck_d    = lrck_q;
    strobe_d  = 1'b0;
    ch_d      = ch_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fe        = (div_q == DIV_LAST);
    frame_end = 1'b0;
    finish    = 1'b0;

    case (state_q)
      IDLE: begin
        bck_d  = 1'b0;
        lrck_d = 1'b0;
        idx_d  = '0;
        div_d  = '0;
        busy_d = 1'b0;
        if (enable) begin
          state_d = RUN;
          nf_d    = num_frames;
          fcnt_d  = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        div_d = fe ? '0 : div_q + DIV_W'(1);
        if (fe) begin
          // Slot wrap toggles lrck; leaving the right slot closes a frame.
          if (idx_q == IDX_LAST) begin
            idx_d     = '0;
            lrck_d    = ~lrck_q;
            frame_end = lrck_q;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (idx_d == STROBE_IDX) begin
            strobe_d = 1'b1;
            ch_d     = lrck_q;
          end
          if (frame_end) fcnt_d = fcnt_q + 16'd1;
        end
        bck_d = (div_d >= DIV_HALF);

        finish = frame_end && ((state_q == DRAIN) || !enable ||
                               ((nf_q != 16'd0) && (fcnt_d == nf_q)));
        if (finish) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          bck_d   = 1'b0;
          lrck_d  = 1'b0;
          idx_d   = '0;
          div_d   = '0;
        end else if ((state_q == RUN) && !enable) begin
          state_d = DRAIN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      idx_q    <= '0;
      fcnt_q   <= '0;
      nf_q     <= '0;
      bck_q    <= 1'b0;
      lrck_q   <= 1'b0;
      strobe_q <= 1'b0;
      ch_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      fcnt_q   <= fcnt_d;
      nf_q     <= nf_d;
      bck_q    <= bck_d;
      lrck_q   <= lrck_d;
      strobe_q <= strobe_d;
      ch_q     <= ch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bck           = bck_q;
  assign lrck          = lrck_q;
  assign bit_idx       = idx_q;
  assign sample_strobe = strobe_q;
  assign sample_ch     = ch_q;
  assign frame_cnt     = fcnt_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// Bench for i2s_clk_ctrl: three parameterisations share stimulus; expected
// outputs come from elapsed-time arithmetic on the bck/slot/frame rules.
module tb_i2s_clk_ctrl;
  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [15:0] num_frames;

  logic [2:0]  bck_w, lrck_w, strobe_w, ch_w, busy_w, done_w;
  logic [4:0]  idx_w [3];
  logic [15:0] fc_w  [3];

  i2s_clk_ctrl #(.DATA_BITS(24), .SLOT_BITS(32), .BCK_DIV(2)) u0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .num_frames(num_frames),
    .bck(bck_w[0]), .lrck(lrck_w[0]), .bit_idx(idx_w[0]),
    .sample_strobe(strobe_w[0]), .sample_ch(ch_w[0]), .frame_cnt(fc_w[0]),
    .busy(busy_w[0]), .done(done_w[0]));

  i2s_clk_ctrl #(.DATA_BITS(24), .SLOT_BITS(32), .BCK_DIV(4)) u1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .num_frames(num_frames),
    .bck(bck_w[1]), .lrck(lrck_w[1]), .bit_idx(idx_w[1]),
    .sample_strobe(strobe_w[1]), .sample_ch(ch_w[1]), .frame_cnt(fc_w[1]),
    .busy(busy_w[1]), .done(done_w[1]));

  i2s_clk_ctrl #(.DATA_BITS(16), .SLOT_BITS(18), .BCK_DIV(2)) u2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .num_frames(num_frames),
    .bck(bck_w[2]), .lrck(lrck_w[2]), .bit_idx(idx_w[2]),
    .sample_strobe(strobe_w[2]), .sample_ch(ch_w[2]), .frame_cnt(fc_w[2]),
    .busy(busy_w[2]), .done(done_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned p_div  [3] = '{2, 4, 2};
  int unsigned p_slot [3] = '{32, 32, 18};
  int unsigned p_data [3] = '{24, 24, 16};

  // Reference state: running flag, drain request, clocks since RUN entry.
  bit          m_run   [3];
  bit          m_drain [3];
  bit          m_done  [3];
  int unsigned m_t     [3];
  int unsigned m_nf    [3];
  int unsigned m_fc    [3];

  int          tests;
  int          fails;
  int unsigned cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input int i);
    int unsigned tn, fl, frames;
    if (!reset_n) begin
      m_run[i] = 0; m_drain[i] = 0; m_done[i] = 0; m_fc[i] = 0; m_t[i] = 0;
    end else if (!m_run[i]) begin
      m_done[i] = 0;
      if (enable) begin
        m_run[i] = 1; m_drain[i] = 0; m_t[i] = 0; m_nf[i] = num_frames; m_fc[i] = 0;
      end
    end else begin
      tn     = m_t[i] + 1;
      fl     = 2 * p_slot[i] * p_div[i];
      frames = (tn / fl) % 65536;
      if ((tn % fl == 0) && (m_drain[i] || !enable || (m_nf[i] != 0 && frames == m_nf[i]))) begin
        m_run[i] = 0; m_fc[i] = frames; m_done[i] = 1;
      end else begin
        m_t[i] = tn;
        if (!enable) m_drain[i] = 1;
      end
    end
  endtask

  task automatic check_dut(input int i);
    int unsigned t, dv, sl, fl, b, idx;
    logic eb, el, es, ebusy, edone;
    logic [15:0] efc;
    dv = p_div[i]; sl = p_slot[i]; fl = 2 * sl * dv;
    if (m_run[i]) begin
      t     = m_t[i];
      b     = t / dv;
      idx   = b % sl;
      eb    = (t % dv) >= dv / 2;
      el    = ((b / sl) % 2) == 1;
      efc   = 16'((t / fl) % 65536);
      es    = (t % dv == 0) && (idx == p_data[i] + 1);
      ebusy = 1'b1;
      edone = 1'b0;
    end else begin
      idx = 0; eb = 1'b0; el = 1'b0; es = 1'b0; ebusy = 1'b0;
      efc   = 16'(m_fc[i]);
      edone = m_done[i];
    end
    check($sformatf("u%0d.bck", i),       32'(bck_w[i]),    32'(eb));
    check($sformatf("u%0d.lrck", i),      32'(lrck_w[i]),   32'(el));
    check($sformatf("u%0d.bit_idx", i),   32'(idx_w[i]),    idx);
    check($sformatf("u%0d.strobe", i),    32'(strobe_w[i]), 32'(es));
    check($sformatf("u%0d.frame_cnt", i), 32'(fc_w[i]),     32'(efc));
    check($sformatf("u%0d.busy", i),      32'(busy_w[i]),   32'(ebusy));
    check($sformatf("u%0d.done", i),      32'(done_w[i]),   32'(edone));
    if (es) check($sformatf("u%0d.sample_ch", i), 32'(ch_w[i]), 32'(el));
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i);
    cyc++;
    #1;
    for (int i = 0; i < 3; i++) check_dut(i);
  endtask

  initial begin
    int unsigned entry;
    int unsigned fs [3];
    int unsigned done0;
    int unsigned nstb0;
    int unsigned n;

    tests = 0; fails = 0; cyc = 0;
    reset_n = 1'b0; enable = 1'b0; num_frames = 16'd0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Two frames at defaults; num_frames changes after entry must be ignored.
    num_frames = 16'd2; enable = 1'b1;
    step();
    entry = cyc;
    fs = '{0, 0, 0}; done0 = 0; nstb0 = 0;
    num_frames = 16'h1234;
    for (int k = 0; k < 300; k++) begin
      step();
      for (int i = 0; i < 3; i++)
        if (strobe_w[i] && fs[i] == 0) fs[i] = cyc - entry;
      if (done_w[0] && done0 == 0) done0 = cyc - entry;
      if (strobe_w[0] && done0 == 0) nstb0++;
    end
    check("u0.first_strobe", fs[0], 50);
    check("u1.first_strobe", fs[1], 100);
    check("u2.first_strobe", fs[2], 34);
    check("u0.done_time", done0, 256);
    check("u0.strobe_count", nstb0, 4);
    enable = 1'b0;
    repeat (600) step();

    // Continuous run, enable dropped in the right slot of frame 3.
    num_frames = 16'd0; enable = 1'b1;
    step();
    repeat (350) step();
    enable = 1'b0;
    repeat (200) step();
    check("u0.drain_frames", 32'(fc_w[0]), 3);

    // Reset mid-run.
    enable = 1'b1;
    repeat (100) step();
    reset_n = 1'b0; enable = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Enable held through done with a single frame.
    num_frames = 16'd1; enable = 1'b1;
    repeat (1100) step();
    enable = 1'b0;
    repeat (600) step();

    for (int ep = 0; ep < 20; ep++) begin
      num_frames = 16'($urandom_range(0, 3));
      enable = 1'b1;
      n = $urandom_range(1, 700);
      for (int k = 0; k < int'(n); k++) begin
        step();
        if ($urandom_range(0, 3) == 0) num_frames = 16'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 3) == 0) begin
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
      end
      n = $urandom_range(1, 700);
      for (int k = 0; k < int'(n); k++) begin
        enable = ($urandom_range(0, 15) == 0);
        step();
      end
      enable = 1'b0;
      repeat (600) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
